// File: rtl/mem_req_arbiter.sv
// Two-requester front end for the cache-side memory controller ring port.
// It allocates transaction IDs from a 16-entry pool, issues request packets and routes each response to the requester that owns its ID.
module mem_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 36,
  parameter int DATA_W  = 512
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_is_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic                           ring_slot_free,
  output logic [2:0]                     ring_pkt_type,
  output logic [3:0]                     ring_id,
  output logic [ADDR_W-1:0]              ring_addr,
  output logic [DATA_W-1:0]              ring_data,
  input  logic [2:0]                     resp_pkt_type,
  input  logic [3:0]                     resp_id,
  input  logic [ADDR_W-1:0]              resp_addr,
  input  logic [DATA_W-1:0]              resp_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_is_write,
  output logic [3:0]                     rsp_id,
  output logic [ADDR_W-1:0]              rsp_addr,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [4:0]                     outstanding,
  output logic                           err_bad_resp
);

  localparam logic [2:0] PKT_EMPTY   = 3'b000;
  localparam logic [2:0] PKT_WR_REQ  = 3'b001;
  localparam logic [2:0] PKT_RD_REQ  = 3'b011;
  localparam logic [2:0] PKT_WR_CMP  = 3'b101;
  localparam logic [2:0] PKT_RD_DATA = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Lowest-numbered clear bit of the allocation bitmap; only used when a free ID exists.
  function automatic logic [3:0] f_lowest_free(input logic [15:0] bm);
    logic [3:0] idx;
    logic       found;
    idx   = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && !bm[i]) begin
        idx   = i[3:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  state_t              r_state;
  logic                r_rr_ptr;
  logic                r_winner;
  logic [15:0]         r_bitmap;
  logic [15:0]         r_owner;
  logic [15:0]         r_is_wr;
  logic [4:0]          r_outstanding;
  logic                r_err;
  logic [2:0]          r_ring_pkt_type;
  logic [3:0]          r_ring_id;
  logic [ADDR_W-1:0]   r_ring_addr;
  logic [DATA_W-1:0]   r_ring_data;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic                r_rsp_is_write;
  logic [3:0]          r_rsp_id;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic [DATA_W-1:0]   r_rsp_data;

  logic                w_full;
  logic                w_grant;
  logic                w_winner;
  logic [3:0]          w_alloc_id;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_resp_rd;
  logic                w_resp_wr;
  logic                w_entry_ok;
  logic                w_free;
  logic                w_resp_bad;
  logic [15:0]         w_bitmap_nxt;

  assign w_full     = (r_outstanding == 5'd16);
  assign w_winner   = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
  assign w_grant    = (r_state == ST_IDLE) && (|req_valid) && !w_full;
  assign w_alloc_id = f_lowest_free(r_bitmap);

  // One-hot accept toward the round-robin winner while a grant is possible.
  always_comb begin
    w_req_ready = '0;
    if (w_grant) begin
      w_req_ready[w_winner] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  assign w_resp_rd  = (resp_pkt_type == PKT_RD_DATA);
  assign w_resp_wr  = (resp_pkt_type == PKT_WR_CMP);
  assign w_entry_ok = r_bitmap[resp_id] && (r_is_wr[resp_id] == w_resp_wr);
  assign w_free     = (w_resp_rd || w_resp_wr) && w_entry_ok;
  assign w_resp_bad = (w_resp_rd || w_resp_wr) && !w_entry_ok;

  // Next allocation bitmap: a free and a grant can land in the same cycle on different IDs.
  always_comb begin
    w_bitmap_nxt = r_bitmap;
    if (w_free) begin
      w_bitmap_nxt[resp_id] = 1'b0;
    end else begin
      w_bitmap_nxt = r_bitmap;
    end
    if (w_grant) begin
      w_bitmap_nxt[w_alloc_id] = 1'b1;
    end else begin
      w_bitmap_nxt[w_alloc_id] = w_bitmap_nxt[w_alloc_id];
    end
  end

  // Request FSM with registered ring-side packet outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_rr_ptr        <= 1'b0;
      r_winner        <= 1'b0;
      r_ring_pkt_type <= PKT_EMPTY;
      r_ring_id       <= 4'd0;
      r_ring_addr     <= '0;
      r_ring_data     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_ring_pkt_type <= req_is_write[w_winner] ? PKT_WR_REQ : PKT_RD_REQ;
            r_ring_id       <= w_alloc_id;
            r_ring_addr     <= req_addr[w_winner];
            r_ring_data     <= req_is_write[w_winner] ? req_data[w_winner] : '0;
            r_winner        <= w_winner;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ring_slot_free) begin
            r_ring_pkt_type <= PKT_EMPTY;
            r_ring_id       <= 4'd0;
            r_ring_addr     <= '0;
            r_ring_data     <= '0;
            r_rr_ptr        <= ~r_winner;
            r_state         <= ST_IDLE;
          end
        end
        default: begin
          r_ring_pkt_type <= PKT_EMPTY;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

  // ID pool bookkeeping: bitmap, owner/type table and allocated-ID count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitmap      <= 16'd0;
      r_owner       <= 16'd0;
      r_is_wr       <= 16'd0;
      r_outstanding <= 5'd0;
      r_err         <= 1'b0;
    end else begin
      r_bitmap <= w_bitmap_nxt;
      if (w_grant) begin
        r_owner[w_alloc_id] <= w_winner;
        r_is_wr[w_alloc_id] <= req_is_write[w_winner];
      end
      case ({w_grant, w_free})
        2'b10:   r_outstanding <= r_outstanding + 5'd1;
        2'b01:   r_outstanding <= r_outstanding - 5'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_resp_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // One-cycle response strobe toward the owner of the completed ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid    <= '0;
      r_rsp_is_write <= 1'b0;
      r_rsp_id       <= 4'd0;
      r_rsp_addr     <= '0;
      r_rsp_data     <= '0;
    end else begin
      r_rsp_valid    <= '0;
      r_rsp_is_write <= 1'b0;
      r_rsp_id       <= 4'd0;
      r_rsp_addr     <= '0;
      r_rsp_data     <= '0;
      if (w_free) begin
        r_rsp_valid[r_owner[resp_id]] <= 1'b1;
        r_rsp_is_write <= w_resp_wr;
        r_rsp_id       <= resp_id;
        r_rsp_addr     <= resp_addr;
        r_rsp_data     <= w_resp_wr ? '0 : resp_data;
      end
    end
  end

  assign req_ready     = w_req_ready;
  assign ring_pkt_type = r_ring_pkt_type;
  assign ring_id       = r_ring_id;
  assign ring_addr     = r_ring_addr;
  assign ring_data     = r_ring_data;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_is_write  = r_rsp_is_write;
  assign rsp_id        = r_rsp_id;
  assign rsp_addr      = r_rsp_addr;
  assign rsp_data      = r_rsp_data;
  assign outstanding   = r_outstanding;
  assign err_bad_resp  = r_err;

endmodule
